// File: rtl/fp_pkg.sv
// Shared types and helpers for the iterative floating-point units.
// Provides rounding modes, exception flags, FSM states, and bias/NaN/LZC helpers.
package fp_pkg;

  localparam int FP_MAX_W = 128;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic invalid;
    logic divzero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_ROUND,
    ST_DONE
  } sqrt_st_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(
    input int exp_w,
    input int man_w
  );
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w+i] = 1'b1;
    end
    v[man_w-1] = 1'b1;
    return v;
  endfunction

  // Leading zeros within the low w bits of v.
  function automatic int fp_lzc(
    input logic [FP_MAX_W-1:0] v,
    input int w
  );
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    for (int i = FP_MAX_W - 1; i >= 0; i--) begin
      if (i < w && !hit) begin
        if (v[i]) hit = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_sqrt_recur_step.sv
// Combinational restoring square-root step, BITS_PER_CYCLE root bits.
// Ports: rem_i/root_i current state, pairs_i next radicand bit pairs (MSB first), rem_o/root_o next state.
module fp_sqrt_recur_step #(
  parameter int ROOT_W         = 25,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*ROOT_W-1:0]         rem_i,
  input  logic [ROOT_W-1:0]           root_i,
  input  logic [2*BITS_PER_CYCLE-1:0] pairs_i,
  output logic [2*ROOT_W-1:0]         rem_o,
  output logic [ROOT_W-1:0]           root_o
);

  localparam int RW = 2 * ROOT_W;

  logic [RW-1:0]     r;
  logic [RW-1:0]     trial;
  logic [ROOT_W-1:0] q;

  always_comb begin
    r     = rem_i;
    q     = root_i;
    trial = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      r     = {r[RW-3:0], pairs_i[2*i +: 2]};
      trial = {{(RW-ROOT_W-2){1'b0}}, q, 2'b01};
      if (r >= trial) begin
        r = r - trial;
        q = {q[ROOT_W-2:0], 1'b1};
      end else begin
        q = {q[ROOT_W-2:0], 1'b0};
      end
    end
    rem_o  = r;
    root_o = q;
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root, digit recurrence, valid/ready on both sides.
// Ports: in_valid/in_ready/in_a/in_rm operand, flush abort, out_valid/out_ready/out_y/out_flags result.
module fp_sqrt_iter #(
  parameter int EXP_W          = 8,
  parameter int MAN_W          = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [2:0]             in_rm,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_y,
  output logic [4:0]             out_flags
);

  import fp_pkg::*;

  localparam int W      = EXP_W + MAN_W + 1;
  localparam int ROOT_W = MAN_W + 2;
  localparam int RW     = 2 * ROOT_W;
  localparam int PW     = 2 * BITS_PER_CYCLE;
  localparam int ITERS  = ROOT_W / BITS_PER_CYCLE;
  localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int SE_W   = EXP_W + $clog2(MAN_W + 1) + 2;

  localparam logic signed [SE_W-1:0] BIAS_S = SE_W'(fp_bias(EXP_W));
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  sqrt_st_e state_q, state_d;
  rm_e      rm_q, rm_d;
  logic [RW-1:0]     rad_q, rad_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [SE_W-1:0] exp_q, exp_d;
  logic [W-1:0]      y_q, y_d;
  fp_flags_t         flags_q, flags_d;

  logic             sign_a;
  logic [EXP_W-1:0] exp_a;
  logic [MAN_W-1:0] frac_a;
  logic is_nan, is_zero, is_neg, is_pinf, is_spec;

  assign {sign_a, exp_a, frac_a} = in_a;
  assign is_nan  = (&exp_a) & (|frac_a);
  assign is_zero = ~(|exp_a) & ~(|frac_a);
  assign is_neg  = sign_a & ~is_nan & ~is_zero;
  assign is_pinf = (&exp_a) & ~(|frac_a) & ~sign_a;
  assign is_spec = is_nan | is_zero | is_neg | is_pinf;

  logic [W-1:0] spec_y;
  fp_flags_t    spec_fl;

  always_comb begin
    spec_y  = '0;
    spec_fl = '0;
    unique case (1'b1)
      is_nan: begin
        spec_y          = QNAN;
        spec_fl.invalid = ~frac_a[MAN_W-1];
      end
      is_zero: spec_y = in_a;
      is_neg: begin
        spec_y          = QNAN;
        spec_fl.invalid = 1'b1;
      end
      is_pinf: spec_y = in_a;
      default: ;
    endcase
  end

  // Subnormals are normalised so the recurrence always sees 1.f;
  // an odd exponent folds one bit into the radicand.
  int lz;
  logic [MAN_W:0]         mant_n;
  logic signed [SE_W-1:0] exp_n;
  logic [RW-1:0]          rad_n;

  always_comb begin
    lz = fp_lzc(FP_MAX_W'(frac_a), MAN_W);
    if (exp_a == '0) begin
      mant_n = {1'b0, frac_a} << (lz + 1);
      exp_n  = -BIAS_S - SE_W'(lz);
    end else begin
      mant_n = {1'b1, frac_a};
      exp_n  = SE_W'(exp_a) - BIAS_S;
    end
    if (exp_n[0]) rad_n = {mant_n, {(MAN_W+3){1'b0}}};
    else          rad_n = {1'b0, mant_n, {(MAN_W+2){1'b0}}};
  end

  logic [RW-1:0]     step_rem;
  logic [ROOT_W-1:0] step_root;

  fp_sqrt_recur_step #(
    .ROOT_W        (ROOT_W),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pairs_i(rad_q[RW-1 -: PW]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  logic guard, sticky, inc;
  logic [MAN_W+1:0]       sum;
  logic signed [SE_W-1:0] exp_h, exp_r;
  logic [MAN_W-1:0]       frac_r;
  logic [W-1:0]           rnd_y;
  fp_flags_t              rnd_fl;
  logic                   unused_bits;

  assign guard  = root_q[0];
  assign sticky = |rem_q;

  always_comb begin
    unique case (rm_q)
      RM_RTZ, RM_RDN: inc = 1'b0;
      RM_RUP:         inc = guard | sticky;
      default:        inc = guard & (root_q[1] | sticky);
    endcase
    sum   = {1'b0, root_q[ROOT_W-1:1]} + {{(MAN_W+1){1'b0}}, inc};
    exp_h = exp_q >>> 1;
    exp_r = exp_h + BIAS_S + {{(SE_W-1){1'b0}}, sum[MAN_W+1]};
    // A carry out means the root rounded up to 2.0.
    frac_r = sum[MAN_W+1] ? '0 : sum[MAN_W-1:0];
    rnd_y  = {1'b0, exp_r[EXP_W-1:0], frac_r};
    rnd_fl = '0;
    rnd_fl.inexact = guard | sticky;
  end

  assign unused_bits = ^{exp_r[SE_W-1:EXP_W], sum[MAN_W]};

  always_comb begin
    state_d = state_q;
    rm_d    = rm_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    y_d     = y_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && in_valid) begin
          rm_d = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);
          if (is_spec) begin
            y_d     = spec_y;
            flags_d = spec_fl;
            state_d = ST_DONE;
          end else begin
            rad_d   = rad_n;
            rem_d   = '0;
            root_d  = '0;
            exp_d   = exp_n;
            cnt_d   = CNT_W'(ITERS - 1);
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d  = step_rem;
          root_d = step_root;
          rad_d  = rad_q << PW;
          if (cnt_q == '0) state_d = ST_ROUND;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_ROUND: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          y_d     = rnd_y;
          flags_d = rnd_fl;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rm_q    <= RM_RNE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_y     = y_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: fp32 (1 bit/cycle) and fp16 (3 bits/cycle) instances.
// Random operands are checked against a real-arithmetic reference model.
module tb_fp_sqrt_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_a, a_out_y;
  logic [2:0]  a_in_rm;
  logic [4:0]  a_out_flags;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_in_a, b_out_y;
  logic [2:0]  b_in_rm;
  logic [4:0]  b_out_flags;

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_rm(a_in_rm), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_y(a_out_y), .out_flags(a_out_flags)
  );

  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10), .BITS_PER_CYCLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_rm(b_in_rm), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_y(b_out_y), .out_flags(b_out_flags)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) repeat (k) p = p * 2.0;
    else        repeat (-k) p = p / 2.0;
    return p;
  endfunction

  // Reference: exact special-case rules, then sqrt in double precision
  // rounded to the target format by the requested mode.
  function automatic void ref_sqrt(
    input  longint unsigned a, input int ew, input int mw,
    input  logic [2:0] rm, input int lat_n,
    output longint unsigned y, output logic [4:0] fl, output int lat
  );
    longint unsigned one, emax, e, f, s, qnan, ti;
    int  bias, ex;
    real x, r0, r, sc, t, fr;
    logic inx, inc;
    one  = 64'd1;
    bias = (1 << (ew - 1)) - 1;
    emax = (one << ew) - one;
    s    = (a >> (ew + mw)) & one;
    e    = (a >> mw) & emax;
    f    = a & ((one << mw) - one);
    qnan = (emax << mw) | (one << (mw - 1));
    fl   = 5'b0;
    lat  = 1;
    y    = 64'd0;
    if (e == emax && f != 0) begin
      y     = qnan;
      fl[4] = (((f >> (mw - 1)) & one) == 64'd0);
    end else if (e == 0 && f == 0) begin
      y = a;
    end else if (s != 0) begin
      y     = qnan;
      fl[4] = 1'b1;
    end else if (e == emax) begin
      y = a;
    end else begin
      if (e == 0) x = real'(f) * pow2(1 - bias - mw);
      else x = real'(f + (one << mw)) * pow2(int'(e) - bias - mw);
      r0 = $sqrt(x);
      r  = r0;
      ex = 0;
      while (r >= 2.0) begin r = r / 2.0; ex++; end
      while (r < 1.0)  begin r = r * 2.0; ex--; end
      sc  = r * pow2(mw);
      t   = $floor(sc);
      fr  = sc - t;
      inx = (fr != 0.0) || (r0 * r0 != x);
      ti  = 64'($rtoi(t));
      case (rm)
        3'd1, 3'd2: inc = 1'b0;
        3'd3:       inc = inx;
        default:    inc = (fr > 0.5);
      endcase
      if (inc) ti = ti + one;
      if (ti == (one << (mw + 1))) begin
        ti = ti >> 1;
        ex++;
      end
      y     = (64'(ex + bias) << mw) | (ti - (one << mw));
      fl[0] = inx;
      lat   = lat_n;
    end
  endfunction

  function automatic longint unsigned gen_op(input int ew, input int mw);
    longint unsigned one, e, f, s;
    int cat;
    one = 64'd1;
    f   = {$urandom(), $urandom()} & ((one << mw) - one);
    s   = 64'd0;
    cat = int'($urandom_range(0, 9));
    case (cat)
      0: e = 64'd0;
      1: begin
        e = 64'($urandom_range(0, (1 << ew) - 1));
        s = 64'($urandom_range(0, 1));
      end
      2: e = (one << ew) - one;
      default: e = 64'($urandom_range(1, (1 << ew) - 2));
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic logic vld(input int d);
    return (d == 0) ? a_out_valid : b_out_valid;
  endfunction

  task automatic drive(input int d, input logic v,
                       input logic [31:0] a, input logic [2:0] rm);
    if (d == 0) begin
      a_in_valid = v; a_in_a = a; a_in_rm = rm;
    end else begin
      b_in_valid = v; b_in_a = a[15:0]; b_in_rm = rm;
    end
  endtask

  // Returns at the negedge of the first cycle after acceptance.
  task automatic start_op(input int d, input logic [31:0] a,
                          input logic [2:0] rm);
    int n;
    n = 0;
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready", 64'(rdy(d)), 64'd1);
    drive(d, 1'b1, a, rm);
    @(negedge clk);
    drive(d, 1'b0, $urandom(), 3'($urandom()));
  endtask

  task automatic wait_vld(input int d, output int lat);
    lat = 1;
    while (!vld(d) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop(input int d);
    if (d == 0) a_out_ready = 1'b1;
    else        b_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  task automatic xact(input int d, input logic [31:0] a, input logic [2:0] rm,
                      output logic [31:0] y, output logic [4:0] fl,
                      output int lat);
    start_op(d, a, rm);
    wait_vld(d, lat);
    y  = (d == 0) ? a_out_y : {16'd0, b_out_y};
    fl = (d == 0) ? a_out_flags : b_out_flags;
    pop(d);
  endtask

  task automatic dir(input int d, input string tag, input logic [31:0] a,
                     input logic [2:0] rm, input logic [31:0] ey,
                     input logic [4:0] efl, input int elat);
    logic [31:0] y;
    logic [4:0]  fl;
    int lat;
    xact(d, a, rm, y, fl, lat);
    chk({tag, "_y"}, 64'(y), 64'(ey));
    chk({tag, "_fl"}, 64'(fl), 64'(efl));
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
  endtask

  task automatic rnd(input int d, input int n);
    longint unsigned op, ey;
    logic [4:0]  efl, fl;
    logic [31:0] y;
    logic [2:0]  rm;
    int elat, lat, ew, mw, ln;
    ew = (d == 0) ? 8 : 5;
    mw = (d == 0) ? 23 : 10;
    ln = (d == 0) ? 27 : 6;
    for (int i = 0; i < n; i++) begin
      op = gen_op(ew, mw);
      rm = 3'($urandom_range(0, 7));
      ref_sqrt(op, ew, mw, rm, ln, ey, efl, elat);
      xact(d, op[31:0], rm, y, fl, lat);
      chk("rnd_y", 64'(y), ey);
      chk("rnd_fl", 64'(fl), 64'(efl));
      chk("rnd_lat", 64'(lat), 64'(elat));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] y0;
    logic stable, seen;
    int lat;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_a = 0; a_in_rm = 0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_a = 0; b_in_rm = 0; b_flush = 0; b_out_ready = 0;
    #2;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_y", 64'(a_out_y), 64'd0);
    chk("rst_flags", 64'(a_out_flags), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir(0, "four", 32'h40800000, 3'd0, 32'h40000000, 5'b00000, 27);
    dir(0, "two_rne", 32'h40000000, 3'd0, 32'h3FB504F3, 5'b00001, 27);
    dir(0, "two_rtz", 32'h40000000, 3'd1, 32'h3FB504F3, 5'b00001, 27);
    dir(0, "two_rup", 32'h40000000, 3'd3, 32'h3FB504F4, 5'b00001, 27);
    dir(0, "min_sub", 32'h00000001, 3'd0, 32'h1A3504F3, 5'b00001, 27);
    dir(0, "neg_one", 32'hBF800000, 3'd0, 32'h7FC00000, 5'b10000, 1);
    dir(0, "snan", 32'h7F800001, 3'd0, 32'h7FC00000, 5'b10000, 1);
    dir(0, "qnan", 32'h7FC00001, 3'd0, 32'h7FC00000, 5'b00000, 1);
    dir(0, "neg_zero", 32'h80000000, 3'd0, 32'h80000000, 5'b00000, 1);
    dir(0, "pinf", 32'h7F800000, 3'd0, 32'h7F800000, 5'b00000, 1);
    dir(1, "h_four", 32'h4400, 3'd0, 32'h4000, 5'b00000, 6);
    dir(1, "h_two", 32'h4000, 3'd0, 32'h3DA8, 5'b00001, 6);

    // Result held while the consumer stalls.
    start_op(0, 32'h40800000, 3'd0);
    wait_vld(0, lat);
    y0 = a_out_y;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (a_out_y !== y0 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("hold_y", 64'(y0), 64'h40000000);
    chk("hold_stable", 64'(stable), 64'd1);
    pop(0);

    // Flush in the fifth ITER cycle.
    start_op(0, 32'h40800000, 3'd0);
    repeat (4) @(negedge clk);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("flush_iter_rdy", 64'(a_in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      seen = seen | a_out_valid;
      @(negedge clk);
    end
    chk("flush_iter_quiet", 64'(seen), 64'd0);

    // Flush while the result is held.
    start_op(0, 32'h40000000, 3'd0);
    wait_vld(0, lat);
    chk("flush_done_vld", 64'(a_out_valid), 64'd1);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("flush_done_drop", 64'(a_out_valid), 64'd0);
    chk("flush_done_rdy", 64'(a_in_ready), 64'd1);

    // Flush beats in_valid in IDLE.
    a_flush = 1'b1;
    drive(0, 1'b1, 32'h40800000, 3'd0);
    @(negedge clk);
    a_flush = 1'b0;
    drive(0, 1'b0, 32'h0, 3'd0);
    chk("flush_idle_rdy", 64'(a_in_ready), 64'd1);
    seen = 1'b0;
    repeat (30) begin
      seen = seen | a_out_valid;
      @(negedge clk);
    end
    chk("flush_idle_quiet", 64'(seen), 64'd0);

    // Reset in the middle of ITER.
    start_op(0, 32'h40000000, 3'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mrst_out_y", 64'(a_out_y), 64'd0);
    chk("mrst_flags", 64'(a_out_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      seen = seen | a_out_valid;
      @(negedge clk);
    end
    chk("mrst_quiet", 64'(seen), 64'd0);
    dir(0, "after_rst", 32'h40800000, 3'd0, 32'h40000000, 5'b00000, 27);

    rnd(0, 60);
    rnd(1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Multi-cycle, parametrised IEEE-754 square-root unit for any binary format set by EXP_W/MAN_W (fp16, fp32, fp64).
- Uses a digit-recurrence pair-bit restoring square root, retiring BITS_PER_CYCLE root bits per clock.
- Supports five IEEE rounding modes and valid/ready handshakes on both sides.
- Sits beside the combinational fp32 divide/sqrt units as the area-lean option for the FPU issue pipeline.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored fraction width (>=2).
- BITS_PER_CYCLE, 1, root bits produced per ITER cycle; 1..ROOT_W, must divide ROOT_W = MAN_W+2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept an operand.
- in_a  in  EXP_W+MAN_W+1  IEEE operand.
- in_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 are treated as RNE.
- flush  in  1  synchronous abort of the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  EXP_W+MAN_W+1  result.
- out_flags  out  5  {invalid, divzero, overflow, underflow, inexact}.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - in_ready=1, out_valid=0, out_y=0, out_flags=0.
  - All datapath registers cleared.
- States: IDLE, ITER, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the operand and rm are captured.
  - Special input goes to DONE with the final result registered. Special means NaN, negative nonzero, ±0 or +inf.
  - Otherwise the state goes to ITER. The operand is normalised in this cycle: a subnormal is shifted by its leading-zero count, the unbiased exponent is computed signed, and the mantissa is pre-shifted one bit when that exponent is odd.
- ITER:
  - Runs exactly ITERS = ROOT_W/BITS_PER_CYCLE cycles, counted by a down-counter.
  - Each cycle, BITS_PER_CYCLE pair-bit steps update the remainder (width 2*ROOT_W) and the root.
  - After the last step the state goes to ROUND.
- ROUND:
  - Guard = root LSB. Sticky = OR of the remainder. Inexact = guard|sticky.
  - Increment rules:
    - RNE/RMM: guard & (lsb|sticky).
    - RTZ/RDN: never.
    - RUP: guard|sticky.
  - Result exponent = (unbiased>>>1) + bias.
  - A mantissa carry-out re-normalises and increments the exponent.
  - Result and flags are registered, then the state goes to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_y and out_flags stay stable until out_ready.
  - On out_valid&out_ready the state goes to IDLE. The earliest new acceptance is the following cycle; there is no same-cycle turnaround.
- Latency from the acceptance edge to out_valid:
  - ITERS+2 cycles for a normal operand (fp32, BITS_PER_CYCLE=1: 27).
  - 1 cycle for a special operand.
- Special results:
  - Any NaN gives the canonical qNaN (sign 0, exponent all ones, fraction MSB only). invalid is set only for an sNaN (fraction MSB=0).
  - Negative nonzero, including -inf and negative subnormals, gives the canonical qNaN with invalid=1.
  - ±0 returns the operand unchanged with no flags.
  - +inf returns +inf with no flags.
- divzero, overflow and underflow are constant 0: a sqrt result is always a finite normal number.
- A halfway tie cannot occur, so RMM and RNE are identical. RDN equals RTZ because results are non-negative.
- flush:
  - In ITER or ROUND: goes to IDLE next cycle, drops the result, out_valid never rises.
  - In DONE: the held result is discarded, out_valid=0 next cycle.
  - In IDLE: has priority over in_valid; nothing is accepted that cycle.
- Reset mid-operation: immediate abort, all outputs at their reset values, no spurious out_valid after release.
- in_a and in_rm are sampled only at acceptance. Later changes have no effect.

Decomposition:
- Package fp_pkg holds:
  - rm_e enum for rounding modes.
  - fp_flags_t packed struct in {invalid, divzero, overflow, underflow, inexact} order.
  - Parameterised canonical-NaN, bias and LZC functions.
- Sub-module fp_sqrt_recur_step: combinational BITS_PER_CYCLE pair-bit step. Parameters ROOT_W and BITS_PER_CYCLE. Inputs remainder, root and operand bit-pairs; outputs updated remainder and root.
- The top level holds the FSM, normalisation, counter and rounding.

Test Plan:
- fp32, RNE: 0x40800000 (4.0) -> 0x40000000, flags 0, out_valid exactly 27 cycles after acceptance.
- fp32 0x40000000 (2.0):
  - RNE -> 0x3FB504F3.
  - RTZ -> 0x3FB504F3.
  - RUP -> 0x3FB504F4.
  - inexact=1 in all three.
- fp32 0x00000001 (min subnormal), RNE -> 0x1A3504F3, inexact.
- fp32 specials:
  - 0xBF800000 -> 0x7FC00000, invalid.
  - 0x7F800001 (sNaN) -> 0x7FC00000, invalid.
  - 0x7FC00001 (qNaN) -> 0x7FC00000, no flags.
  - 0x80000000 -> 0x80000000, no flags.
  - Each returns out_valid 1 cycle after acceptance.
- Handshake/abort:
  - Hold out_ready=0 for 10 cycles: out_y stable, in_ready=0.
  - Assert flush in ITER cycle 5: no out_valid, in_ready=1 next cycle.
  - Assert rst_n=0 mid-ITER: outputs reset.
- EXP_W=5, MAN_W=10, BITS_PER_CYCLE=3:
  - 0x4400 -> 0x4000 after 6 cycles.
  - 0x4000 RNE -> 0x3DA8, inexact.
